// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, register-master FSM states and the latched command payload.
package axil_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int unsigned AXIL_ADDR_W = 11;
    localparam int unsigned AXIL_DATA_W = 32;
    localparam int unsigned AXIL_STRB_W = AXIL_DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_B,
        ST_RD_A,
        ST_RD_R,
        ST_RSP
    } axil_mst_state_t;

    typedef struct packed {
        logic                   rnw;
        logic [AXIL_ADDR_W-1:0] addr;
        logic [AXIL_DATA_W-1:0] wdata;
        logic [AXIL_STRB_W-1:0] wstrb;
    } axil_cmd_t;

endpackage

// File: rtl/axil_reg_master.sv
// AXI4-Lite initiator, one outstanding register read/write at a time.
// Optional watchdog: define AXIL_TIMEOUT_EN to abandon a stalled transaction after TIMEOUT_CYCLES clocks.
module axil_reg_master
    import axil_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = AXIL_ADDR_W,
    parameter int unsigned C_M_AXI_DATA_WIDTH = AXIL_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_rnw,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic                            busy,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int unsigned STRB_W = C_M_AXI_DATA_WIDTH / 8;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("axil_reg_master: TIMEOUT_CYCLES must be >= 2");
    end

    axil_mst_state_t state;
    axil_cmd_t       cmd_in;
    axil_cmd_t       cmd_q;
    logic [1:0]      rst_sync;
    logic            rst_n_sync;
    logic            cmd_accept_c;

    // Reset asserts asynchronously, releases two clocks after M_AXI_ARESETN rises
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) rst_sync <= 2'b00;
        else                rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_sync = rst_sync[1];

    assign cmd_in = '{rnw:   cmd_rnw,
                      addr:  AXIL_ADDR_W'(cmd_addr),
                      wdata: AXIL_DATA_W'(cmd_wdata),
                      wstrb: AXIL_STRB_W'(cmd_wstrb)};

    assign cmd_accept_c = (state == ST_IDLE) && cmd_valid && cmd_ready;

    assign M_AXI_AWADDR = C_M_AXI_ADDR_WIDTH'(cmd_q.addr);
    assign M_AXI_ARADDR = C_M_AXI_ADDR_WIDTH'(cmd_q.addr);
    assign M_AXI_WDATA  = C_M_AXI_DATA_WIDTH'(cmd_q.wdata);
    assign M_AXI_WSTRB  = STRB_W'(cmd_q.wstrb);
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;

`ifdef AXIL_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_expire_c;
    logic            rsp_timeout_q;

    assign wd_expire_c = (state != ST_IDLE) && (state != ST_RSP) &&
                         (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge M_AXI_ACLK or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state         <= ST_IDLE;
            cmd_q         <= '0;
            cmd_ready     <= 1'b0;
            busy          <= 1'b0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= AXI_RESP_OKAY;
`ifdef AXIL_TIMEOUT_EN
            wd_cnt        <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_accept_c) begin
                        cmd_q     <= cmd_in;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_in.rnw) begin
                            M_AXI_ARVALID <= 1'b1;
                            state         <= ST_RD_A;
                        end else begin
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= ST_WR;
                        end
                    end
                end
                // AW and W complete independently; leave once neither is pending
                ST_WR: begin
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
                    if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= ST_WR_B;
                    end
                end
                ST_RD_A: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= ST_RD_R;
                    end
                end
                ST_WR_B, ST_RD_R: begin
                    if (cmd_q.rnw ? M_AXI_RVALID : M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        M_AXI_RREADY <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_resp     <= cmd_q.rnw ? M_AXI_RRESP : M_AXI_BRESP;
                        rsp_rdata    <= cmd_q.rnw ? M_AXI_RDATA : '0;
                        state        <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
`ifdef AXIL_TIMEOUT_EN
            // Watchdog overrides any in-flight handshake; the bus needs a reset afterwards
            if (cmd_accept_c) begin
                wd_cnt        <= '0;
                rsp_timeout_q <= 1'b0;
            end else if (wd_expire_c) begin
                M_AXI_AWVALID <= 1'b0;
                M_AXI_WVALID  <= 1'b0;
                M_AXI_BREADY  <= 1'b0;
                M_AXI_ARVALID <= 1'b0;
                M_AXI_RREADY  <= 1'b0;
                rsp_valid     <= 1'b1;
                rsp_resp      <= AXI_RESP_SLVERR;
                rsp_rdata     <= '0;
                rsp_timeout_q <= 1'b1;
                state         <= ST_RSP;
            end else if ((state != ST_IDLE) && (state != ST_RSP)) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
`endif
        end
    end

endmodule
